// File: rtl/serial_subtractor_ctrl.sv
// serial_subtractor_ctrl: W = 4*NIBBLES bit subtract x - y - bin using one 4-bit ripple-borrow slice, LSB nibble first.
// Latency: NIBBLES edges from the accepting edge to done; one result per NIBBLES+1 cycles (back-to-back through DONE).
// Backpressure: none; start is only accepted in IDLE or DONE, and is dropped (not queued) while busy.
//
// Ports:
//   clock, reset_ (async, active-low)
//   start, x[W-1:0], y[W-1:0], bin  : request and operands, sampled on the accepting edge
//   busy                            : high while nibbles are being processed
//   done                            : one-cycle pulse, result valid
//   d[W-1:0], bout, ow              : registered difference, borrow out, signed overflow
//   z                               : zero flag, present only when SERIAL_SUB_ZERO_EN is defined
//
// Optional feature macro: SERIAL_SUB_ZERO_EN

module n4_b2_subtractor (
    input  logic [3:0] i_a,
    input  logic [3:0] i_b,
    input  logic       i_bin,
    output logic [3:0] o_d3_d0,
    output logic       o_bout,
    output logic       o_ow
);
    always_comb begin : ripple
        logic v_br;
        v_br    = i_bin;
        o_d3_d0 = '0;
        for (int i = 0; i < 4; i++) begin
            o_d3_d0[i] = i_a[i] ^ i_b[i] ^ v_br;
            v_br       = (~i_a[i] & i_b[i]) | (~(i_a[i] ^ i_b[i]) & v_br);
        end
        o_bout = v_br;
    end

    // Subtraction overflows only when operand signs differ and the result sign leaves the minuend's.
    assign o_ow = (i_a[3] ^ i_b[3]) & (i_a[3] ^ o_d3_d0[3]);
endmodule

module serial_subtractor_ctrl #(
    parameter int NIBBLES = 4
) (
    input  logic                   clock,
    input  logic                   reset_,
    input  logic                   start,
    input  logic [4*NIBBLES-1:0]   x,
    input  logic [4*NIBBLES-1:0]   y,
    input  logic                   bin,
    output logic                   busy,
    output logic                   done,
    output logic [4*NIBBLES-1:0]   d,
    output logic                   bout,
    output logic                   ow
`ifdef SERIAL_SUB_ZERO_EN
    ,
    output logic                   z
`endif
);
    localparam int W  = 4 * NIBBLES;
    localparam int IW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [IW-1:0]   r_idx;
    logic [W-1:0]    r_x;
    logic [W-1:0]    r_y;
    logic [W-1:0]    r_d;
    logic            r_br;
    logic            r_bout;
    logic            r_ow;
    logic            w_accept;
    logic            w_last;
    logic [3:0]      w_nib;
    logic            w_bout;
    logic            w_ow;

    assign w_accept = start && ((r_state == S_IDLE) || (r_state == S_DONE));
    assign w_last   = (r_idx == IW'(NIBBLES - 1));

    n4_b2_subtractor n4_b2_subtractor_i (
        .i_a     (r_x[4*r_idx +: 4]),
        .i_b     (r_y[4*r_idx +: 4]),
        .i_bin   (r_br),
        .o_d3_d0 (w_nib),
        .o_bout  (w_bout),
        .o_ow    (w_ow)
    );

    always_ff @(posedge clock or negedge reset_) begin
        if (!reset_) r_state <= S_IDLE;
        else         r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE:  if (start) w_state_nxt = S_RUN;
            S_RUN:   if (w_last) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = start ? S_RUN : S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_) begin
        if (!reset_) begin
            r_idx  <= '0;
            r_x    <= '0;
            r_y    <= '0;
            r_d    <= '0;
            r_br   <= 1'b0;
            r_bout <= 1'b0;
            r_ow   <= 1'b0;
        end else if (w_accept) begin
            r_x   <= x;
            r_y   <= y;
            r_br  <= bin;
            r_d   <= '0;
            r_idx <= '0;
        end else if (r_state == S_RUN) begin
            r_d[4*r_idx +: 4] <= w_nib;
            r_br              <= w_bout;
            if (w_last) begin
                // Only the top nibble's overflow describes the full-width signed result.
                r_bout <= w_bout;
                r_ow   <= w_ow;
            end else begin
                r_idx <= r_idx + 1'b1;
            end
        end
    end

`ifdef SERIAL_SUB_ZERO_EN
    logic r_z;
    always_ff @(posedge clock or negedge reset_) begin
        if (!reset_) begin
            r_z <= 1'b0;
        end else if (w_accept) begin
            r_z <= 1'b0;
        end else if ((r_state == S_RUN) && w_last) begin
            // Lower nibbles are already final; the top nibble is still on the slice output.
            r_z <= (r_d[W-5:0] == '0) && (w_nib == 4'd0);
        end
    end
    assign z = r_z;
`endif

    assign busy = (r_state == S_RUN);
    assign done = (r_state == S_DONE);
    assign d    = r_d;
    assign bout = r_bout;
    assign ow   = r_ow;
endmodule

// File: tb/tb_serial_subtractor_ctrl.sv
module tb_serial_subtractor_ctrl;
    localparam int NIB = 4;
    localparam int W   = 4 * NIB;

    logic           clock = 1'b0;
    logic           reset_;
    logic           start;
    logic [W-1:0]   x;
    logic [W-1:0]   y;
    logic           bin;
    logic           busy;
    logic           done;
    logic [W-1:0]   d;
    logic           bout;
    logic           ow;
`ifdef SERIAL_SUB_ZERO_EN
    logic           z;
`endif

    serial_subtractor_ctrl #(.NIBBLES(NIB)) dut (
        .clock  (clock),
        .reset_ (reset_),
        .start  (start),
        .x      (x),
        .y      (y),
        .bin    (bin),
        .busy   (busy),
        .done   (done),
        .d      (d),
        .bout   (bout),
        .ow     (ow)
`ifdef SERIAL_SUB_ZERO_EN
        ,
        .z      (z)
`endif
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [W-1:0] d;
        logic         bout;
        logic         ow;
        logic         z;
    } res_t;

    res_t exp_q[$];
    res_t e;
    res_t last;
    int   checks   = 0;
    int   failures = 0;
    int   n_issued = 0;
    int   n_done   = 0;
    int   busy_run = 0;
    logic prev_done = 1'b0;

    // Reference: plain integer arithmetic on unsigned and signed interpretations.
    function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic bi);
        res_t   r;
        longint ua, ub, lb, diff, sa, sb, sd;
        ua   = longint'(a);
        ub   = longint'(b);
        lb   = bi ? 64'sd1 : 64'sd0;
        diff = ua - ub - lb;
        r.bout = (diff < 0);
        r.d    = W'(diff + (r.bout ? (64'sd1 <<< W) : 64'sd0));
        sa = a[W-1] ? ua - (64'sd1 <<< W) : ua;
        sb = b[W-1] ? ub - (64'sd1 <<< W) : ub;
        sd = sa - sb - lb;
        r.ow = (sd > ((64'sd1 <<< (W-1)) - 1)) || (sd < -(64'sd1 <<< (W-1)));
        r.z  = (r.d == '0);
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, expv, $time);
        end
    endtask

    // Monitor / scoreboard
    always @(negedge clock) begin
        if (!reset_) begin
            busy_run  = 0;
            prev_done = 1'b0;
            last      = '0;
        end else begin
            if (busy) begin
                busy_run++;
            end else if (busy_run != 0) begin
                chk("busy_len", 64'(busy_run), 64'(NIB));
                busy_run = 0;
            end
            if (done) begin
                chk("done_single_pulse", 64'(prev_done), 64'd0);
                n_done++;
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_done actual=done expected=no_done at %0t", $time);
                end else begin
                    e = exp_q.pop_front();
                    chk("d", 64'(d), 64'(e.d));
                    chk("bout", 64'(bout), 64'(e.bout));
                    chk("ow", 64'(ow), 64'(e.ow));
`ifdef SERIAL_SUB_ZERO_EN
                    chk("z", 64'(z), 64'(e.z));
`endif
                    last = e;
                end
            end else if (!busy) begin
                chk("d_hold", 64'(d), 64'(last.d));
                chk("bout_hold", 64'(bout), 64'(last.bout));
                chk("ow_hold", 64'(ow), 64'(last.ow));
            end
            prev_done = done;
        end
    end

    // Drive a request; returns #1 after the accepting edge.
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic bi);
        start = 1'b1;
        x     = a;
        y     = b;
        bin   = bi;
        @(posedge clock);
        exp_q.push_back(model(a, b, bi));
        n_issued++;
        #1;
        start = 1'b0;
        x     = W'($urandom);
        y     = W'($urandom);
        bin   = 1'($urandom);
    endtask

    // From #1 after the accepting edge to #1 after edge NIB (DONE cycle).
    task automatic run_out();
        repeat (NIB) @(posedge clock);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    initial begin
        logic [W-1:0] ra, rb;
        reset_ = 1'b0;
        start  = 1'b0;
        x      = '0;
        y      = '0;
        bin    = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_d", 64'(d), 64'd0);
        chk("rst_bout", 64'(bout), 64'd0);
        chk("rst_ow", 64'(ow), 64'd0);
        reset_ = 1'b1;
        idle(1);

        issue(16'h1234, 16'h0234, 1'b0); run_out(); idle(1);
        issue(16'h0000, 16'h0001, 1'b0); run_out(); idle(1);
        issue(16'h8000, 16'h0001, 1'b0); run_out(); idle(2);
        issue(16'h7FFF, 16'hFFFF, 1'b0); run_out(); idle(1);

        // Back-to-back through DONE: the second op must start with no IDLE cycle.
        issue(16'h0005, 16'h0003, 1'b1); run_out();
        issue(16'h0ABC, 16'h0ABC, 1'b0);
        chk("b2b_busy", 64'(busy), 64'd1);
        run_out(); idle(1);

        // start during RUN is dropped.
        issue(16'h4321, 16'h1111, 1'b0);
        idle(1);
        start = 1'b1; x = 16'hFFFF; y = 16'h0001; bin = 1'b1;
        idle(1);
        start = 1'b0;
        repeat (NIB - 2) @(posedge clock);
        #1;
        chk("midrun_done", 64'(done), 64'd1);
        idle(2);

        // Reset after edge 2 aborts the operation.
        issue(16'hC0DE, 16'h1234, 1'b1);
        idle(2);
        reset_ = 1'b0;
        #1;
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_done", 64'(done), 64'd0);
        chk("abort_d", 64'(d), 64'd0);
        chk("abort_bout", 64'(bout), 64'd0);
        chk("abort_ow", 64'(ow), 64'd0);
        exp_q.delete();
        n_issued--;
        idle(2);
        reset_ = 1'b1;
        idle(1);
        issue(16'h00FF, 16'h0100, 1'b0); run_out(); idle(1);

        // Randomized traffic, mixing idle gaps and back-to-back requests.
        for (int i = 0; i < 60; i++) begin
            ra = W'($urandom);
            rb = ($urandom_range(0, 3) == 0) ? ra : W'($urandom);
            issue(ra, rb, 1'($urandom));
            run_out();
            if ($urandom_range(0, 2) != 0) idle($urandom_range(1, 3));
        end
        idle(3);

        chk("done_count", 64'(n_done), 64'(n_issued));
        chk("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
